store_rmw_ctrl: RTL

- Multicycle sequencer for sub-word stores (sb/sh/sw).
- For byte and halfword stores it performs a read-modify-write: reads the old word, loads it into MDR, selects the store-size merge, then writes the merged word.
- Word stores skip the read phase.
- Sits between the main control unit and the memory/MDR/store-size datapath, and drives the store-size select.

---
 rtl/store_size_pkg.sv | 31 +++
 rtl/store_rmw_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/store_size_pkg.sv
// Store-size selects and sequencer state encoding shared by the store path
// (merge unit, main control and the read-modify-write sequencer).
package store_size_pkg;

  localparam logic [1:0] SS_BYTE = 2'b00;
  localparam logic [1:0] SS_HALF = 2'b01;
  localparam logic [1:0] SS_WORD = 2'b10;
  localparam logic [1:0] SS_KEEP = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LATCH = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } store_state_t;

  // Illegal size, or an address not aligned to the access size.
  function automatic logic store_req_bad(input logic [1:0] stype, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (stype)
      SS_BYTE: bad = 1'b0;
      SS_HALF: bad = lo[0];
      SS_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_rmw_ctrl.sv
// Multicycle sequencer for sb/sh/sw: sub-word stores read the old word into
// MDR before the merged write; word stores write directly.
module store_rmw_ctrl
  import store_size_pkg::*;
#(
  parameter int MEM_RD_LAT = 1,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic        mdr_load,
  output logic [1:0]  ss_control,
  output logic [31:0] store_data
);

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(MEM_RD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  store_state_t     state_q, state_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic [31:0]      addr_q, data_q;
  logic [1:0]       type_q;
  logic             err_q;
  logic             capture;
  logic             req_bad;

  assign capture = (state_q == ST_IDLE) && start;
  assign req_bad = store_req_bad(store_type, addr[1:0]);

  // Request capture: operands are frozen here for the whole operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      type_q  <= SS_KEEP;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      if (capture) begin
        addr_q <= addr;
        data_q <= wdata;
        type_q <= store_type;
        err_q  <= req_bad;
      end
    end
  end

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (req_bad) begin
            state_nx = ST_DONE;
          end else if (store_type == SS_WORD) begin
            state_nx = ST_WRITE;
          end else begin
            state_nx = ST_READ;
            cnt_nx   = RD_LOAD;
          end
        end
      end
      // Counter reaching zero marks the last cycle of the read latency.
      ST_READ: begin
        if (cnt_q == '0) begin
          state_nx = ST_LATCH;
        end else begin
          cnt_nx = cnt_q - CNT_ONE;
        end
      end
      ST_LATCH: state_nx = ST_WRITE;
      ST_WRITE: state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    done       = 1'b0;
    err        = 1'b0;
    mem_wr     = 1'b0;
    mdr_load   = 1'b0;
    ss_control = SS_KEEP;
    case (state_q)
      ST_LATCH: mdr_load = 1'b1;
      ST_WRITE: begin
        mem_wr     = 1'b1;
        ss_control = type_q;
      end
      ST_DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

  assign mem_addr   = addr_q;
  assign store_data = data_q;

endmodule
